// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: shifts bitstream words LSB-first into a gated ccff
// chain, with an optional re-shift pass that counts mismatches seen at the tail.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | chain clock gated off, requesting the next word
// SHIFT | one bit per cycle into the chain head
// DONE  | one-cycle completion pulse
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt
);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int WIDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BIDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
  localparam logic [BIDX_W-1:0] FULL_TOP  = BIDX_W'(WORD_W - 1);
  localparam logic [BIDX_W-1:0] LAST_TOP  = BIDX_W'(LAST_BITS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_verify;
  logic                r_pass;
  logic [WIDX_W-1:0]   r_word_idx;
  logic [BIDX_W-1:0]   r_bit_idx;
  logic [WORD_W-1:0]   r_word;
  logic [15:0]         r_err_cnt;

  logic                w_last_word;
  logic                w_last_bit;
  logic                w_xfer;

  assign w_last_word = (r_word_idx == LAST_WORD);
  assign w_last_bit  = (r_bit_idx == (w_last_word ? LAST_TOP : FULL_TOP));

  // Prefetch on the last bit of a non-final word keeps the chain clock running.
  assign cfg_ready   = (r_state == FETCH) ||
                       ((r_state == SHIFT) && w_last_bit && !w_last_word);
  assign w_xfer      = cfg_ready && cfg_valid;

  assign prog_clk_en = (r_state == SHIFT);
  assign ccff_head   = prog_clk_en && r_word[r_bit_idx];
  assign busy        = (r_state == FETCH) || (r_state == SHIFT);
  assign done        = (r_state == DONE);
  assign err_cnt     = r_err_cnt;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = FETCH;
      FETCH: if (w_xfer) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_last_bit) begin
          if (w_last_word)  w_state_nxt = (!r_pass && r_verify) ? FETCH : DONE;
          else if (!w_xfer) w_state_nxt = FETCH;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_verify   <= 1'b0;
      r_pass     <= 1'b0;
      r_word_idx <= '0;
      r_bit_idx  <= '0;
      r_word     <= '0;
      r_err_cnt  <= '0;
    end else if (!abort) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_verify   <= verify;
            r_err_cnt  <= '0;
            r_pass     <= 1'b0;
            r_word_idx <= '0;
            r_bit_idx  <= '0;
          end
        end
        FETCH: begin
          if (w_xfer) begin
            r_word    <= cfg_data;
            r_bit_idx <= '0;
          end
        end
        SHIFT: begin
          // Tail at shift k of the second pass carries the bit loaded at shift k.
          if (r_pass && (ccff_tail != ccff_head) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
          if (w_last_bit) begin
            r_bit_idx <= '0;
            if (w_last_word) begin
              r_word_idx <= '0;
              r_pass     <= 1'b1;
            end else begin
              r_word_idx <= r_word_idx + WIDX_W'(1);
              if (w_xfer) r_word <= cfg_data;
            end
          end else begin
            r_bit_idx <= r_bit_idx + BIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 20-bit and a 16-bit chain instance,
// behavioural chain models, expected head bits and err counts queued at stimulus.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start20, verify20, abort20, valid20, ready20, head20, en20;
  logic        busy20, done20, tail20;
  logic [7:0]  data20;
  logic [15:0] err20;
  logic        start16, verify16, abort16, valid16, ready16, head16, en16;
  logic        busy16, done16, tail16;
  logic [7:0]  data16;
  logic [15:0] err16;

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u20 (
    .prog_clk(clk), .pReset(rst), .start(start20), .verify(verify20), .abort(abort20),
    .cfg_data(data20), .cfg_valid(valid20), .cfg_ready(ready20), .ccff_head(head20),
    .prog_clk_en(en20), .ccff_tail(tail20), .busy(busy20), .done(done20), .err_cnt(err20)
  );

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
    .prog_clk(clk), .pReset(rst), .start(start16), .verify(verify16), .abort(abort16),
    .cfg_data(data16), .cfg_valid(valid16), .cfg_ready(ready16), .ccff_head(head16),
    .prog_clk_en(en16), .ccff_tail(tail16), .busy(busy16), .done(done16), .err_cnt(err16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural chains; fault forces ff 7 of the 20-bit chain to 0 after each shift.
  logic        fault = 1'b0;
  logic [19:0] chain20 = '0;
  logic [15:0] chain16 = '0;
  assign tail20 = chain20[19];
  assign tail16 = chain16[15];

  always @(posedge clk) begin : chain_model
    logic [19:0] n;
    if (en20) begin
      n = {chain20[18:0], head20};
      if (fault) n[7] = 1'b0;
      chain20 <= n;
    end
    if (en16) chain16 <= {chain16[14:0], head16};
  end

  function automatic int model_err(input logic [19:0] init, input logic [19:0] bits,
                                   input logic flt);
    logic [19:0] c;
    int e;
    c = init;
    e = 0;
    for (int k = 0; k < 20; k++) begin
      c = {c[18:0], bits[k]};
      if (flt) c[7] = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      if (c[19] != bits[k]) e++;
      c = {c[18:0], bits[k]};
      if (flt) c[7] = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitors
  bit exp_q[$];
  int exp_err_q[$];
  bit exp16_q[$];
  bit sb_on = 1'b1;
  int en_cnt, gap_cnt, done_cnt, hs_cnt;
  int en16_cnt, gap16_cnt, done16_cnt, hs16_cnt;

  always @(negedge clk) begin
    if (!rst) begin
      if (en20) begin
        en_cnt++;
        if (sb_on) begin
          check("sb20_has_bit", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) check("head20_bit", 32'(head20), 32'(exp_q.pop_front()));
        end
      end else begin
        check("head20_idle", 32'(head20), 32'd0);
        if (busy20) gap_cnt++;
      end
      if (ready20 && valid20) hs_cnt++;
      if (done20) begin
        done_cnt++;
        if (sb_on) begin
          check("sb20_has_err", 32'(exp_err_q.size() > 0), 32'd1);
          if (exp_err_q.size() > 0) check("err_cnt_at_done", 32'(err20), 32'(exp_err_q.pop_front()));
        end
      end
      if (en16) begin
        en16_cnt++;
        check("sb16_has_bit", 32'(exp16_q.size() > 0), 32'd1);
        if (exp16_q.size() > 0) check("head16_bit", 32'(head16), 32'(exp16_q.pop_front()));
      end else if (busy16) begin
        gap16_cnt++;
      end
      if (ready16 && valid16) hs16_cnt++;
      if (done16) done16_cnt++;
    end
  end

  task automatic push_word(input logic [7:0] w);
    int g;
    g = 0;
    valid20 = 1'b1;
    data20  = w;
    while (!ready20 && g < 300) begin
      tick();
      g++;
    end
    if (!ready20) check("drv_ready_timeout", 32'(ready20), 32'd1);
    tick();
    valid20 = 1'b0;
  endtask

  task automatic clear_counts();
    en_cnt = 0; gap_cnt = 0; done_cnt = 0; hs_cnt = 0;
  endtask

  task automatic run_load(input string tag, input logic vfy, input logic flt,
                          input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int stall_len, input int start_at);
    logic [19:0] bits;
    logic [19:0] exp_chain;
    int npass;
    int lat;
    bits  = {w2[3:0], w1, w0};
    npass = vfy ? 2 : 1;
    fault = flt;
    clear_counts();
    for (int p = 0; p < npass; p++)
      for (int k = 0; k < 20; k++) exp_q.push_back(bits[k]);
    exp_err_q.push_back(vfy ? model_err(chain20, bits, flt) : 0);
    start20 = 1'b1; verify20 = vfy;
    tick();
    start20 = 1'b0; verify20 = 1'b0;
    lat = 0;
    fork
      begin
        for (int p = 0; p < npass; p++) begin
          push_word(w0);
          push_word(w1);
          if (p == 0 && stall_len > 0) begin
            int gs;
            gs = 0;
            valid20 = 1'b0;
            while (!ready20 && gs < 300) begin tick(); gs++; end
            repeat (stall_len) tick();
          end
          push_word(w2);
        end
      end
      begin
        bit pulsed;
        pulsed = 1'b0;
        while (done_cnt == 0 && lat < 500) begin
          if (start_at > 0 && !pulsed && en_cnt == start_at) begin
            pulsed  = 1'b1;
            start20 = 1'b1;
            tick();
            start20 = 1'b0;
          end else begin
            tick();
          end
          lat++;
        end
      end
    join
    repeat (3) tick();
    check({tag, "_latency"}, 32'(lat), 32'(npass * 21 + 1 + stall_len));
    check({tag, "_shifts"}, 32'(en_cnt), 32'(npass * 20));
    check({tag, "_gaps"}, 32'(gap_cnt), 32'(npass + stall_len));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_handshakes"}, 32'(hs_cnt), 32'(npass * 3));
    check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy20), 32'd0);
    if (!flt) begin
      for (int i = 0; i < 20; i++) exp_chain[i] = bits[19 - i];
      check({tag, "_chain"}, 32'(chain20), 32'(exp_chain));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready20), 32'd0);
    check({tag, "_head"}, 32'(head20), 32'd0);
    check({tag, "_en"}, 32'(en20), 32'd0);
    check({tag, "_busy"}, 32'(busy20), 32'd0);
    check({tag, "_done"}, 32'(done20), 32'd0);
    check({tag, "_err"}, 32'(err20), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [15:0] bits16;
    logic [15:0] exp16;
    rst = 1'b1;
    start20 = 0; verify20 = 0; abort20 = 0; valid20 = 0; data20 = '0;
    start16 = 0; verify16 = 0; abort16 = 0; valid16 = 0; data16 = '0;
    repeat (3) tick();
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_release");

    run_load("basic", 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h09, 0, 0);
    run_load("stall", 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hF9, 5, 0);
    run_load("vfy_clean", 1'b1, 1'b0, 8'hA5, 8'h3C, 8'h09, 0, 0);
    check("vfy_clean_err_hold", 32'(err20), 32'd0);
    run_load("vfy_fault", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h0F, 0, 25);
    check("vfy_fault_err_hold", 32'(err20), 32'd20);

    // Abort at shift 9
    fault = 1'b0; sb_on = 1'b0;
    clear_counts();
    valid20 = 1'b1; data20 = 8'hA5;
    start20 = 1'b1; tick(); start20 = 1'b0;
    g = 0;
    while (en_cnt != 9 && g < 100) begin tick(); g++; end
    check("abort_at_shift9_en", 32'(en20), 32'd1);
    abort20 = 1'b1;
    tick();
    abort20 = 1'b0;
    check("abort_busy", 32'(busy20), 32'd0);
    check("abort_en", 32'(en20), 32'd0);
    check("abort_ready", 32'(ready20), 32'd0);
    repeat (6) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_shift_count", 32'(en_cnt), 32'd10);
    start20 = 1'b1; abort20 = 1'b1;
    tick();
    start20 = 1'b0; abort20 = 1'b0;
    check("abort_over_start", 32'(busy20), 32'd0);
    valid20 = 1'b0;

    // Reset at pass-1 shift 9 of a faulty verify load
    fault = 1'b1;
    clear_counts();
    valid20 = 1'b1; data20 = 8'hFF;
    start20 = 1'b1; verify20 = 1'b1; tick(); start20 = 1'b0; verify20 = 1'b0;
    g = 0;
    while (en_cnt != 29 && g < 200) begin tick(); g++; end
    check("pre_reset_err", 32'(err20), 32'd9);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    valid20 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_reset_no_done", 32'(done_cnt), 32'd0);
    sb_on = 1'b1;
    run_load("after_reset", 1'b0, 1'b0, 8'hA5, 8'h3C, 8'h09, 0, 0);

    // 16-bit chain: two full words, no partial word
    bits16 = {8'hC3, 8'h5A};
    for (int k = 0; k < 16; k++) exp16_q.push_back(bits16[k]);
    en16_cnt = 0; gap16_cnt = 0; done16_cnt = 0; hs16_cnt = 0;
    start16 = 1'b1; tick(); start16 = 1'b0;
    valid16 = 1'b1; data16 = 8'h5A;
    g = 0;
    while (done16_cnt == 0 && g < 200) begin
      if (ready16) begin
        tick();
        data16 = 8'hC3;
      end else begin
        tick();
      end
      g++;
    end
    repeat (3) tick();
    valid16 = 1'b0;
    for (int i = 0; i < 16; i++) exp16[i] = bits16[15 - i];
    check("c16_shifts", 32'(en16_cnt), 32'd16);
    check("c16_handshakes", 32'(hs16_cnt), 32'd2);
    check("c16_gaps", 32'(gap16_cnt), 32'd1);
    check("c16_done_pulses", 32'(done16_cnt), 32'd1);
    check("c16_chain", 32'(chain16), 32'(exp16));
    check("c16_sb_drained", 32'(exp16_q.size()), 32'd0);
    check("c16_err", 32'(err16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
